// File: rtl/lcd_ctrl.sv
// HD44780 write-only controller: GO-toggle requests are queued in a small FIFO
// and replayed as SETUP / EN pulse / HOLD / execution-wait bus cycles.
module lcd_ctrl #(
  parameter int T_SETUP = 4,
  parameter int T_EN    = 25,
  parameter int T_HOLD  = 4,
  parameter int T_EXEC  = 2000,
  parameter int T_CLEAR = 82000,
  parameter int DEPTH   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lcd_word_i,
  output logic        lcd_on_o,
  output logic        lcd_en_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic [7:0]  lcd_data_o,
  output logic [31:0] lcd_status_o
);

  localparam int T_MAX_0 = (T_SETUP > T_EN)    ? T_SETUP : T_EN;
  localparam int T_MAX_1 = (T_MAX_0 > T_HOLD)  ? T_MAX_0 : T_HOLD;
  localparam int T_MAX_2 = (T_MAX_1 > T_EXEC)  ? T_MAX_1 : T_EXEC;
  localparam int T_MAX   = (T_MAX_2 > T_CLEAR) ? T_MAX_2 : T_CLEAR;
  localparam int CNT_W   = $clog2(T_MAX + 1);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int OCC_W   = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [8:0]       mem_q [DEPTH];
  logic             go_q, on_q, en_q, rs_q, ovf_q;
  logic [7:0]       data_q;

  logic       req, pop, push, fifo_empty, fifo_full, wait_clear, busy;
  logic [8:0] head;
  logic       unused_word_bits;

  assign unused_word_bits = ^{lcd_word_i[30:11], lcd_word_i[8]};

  // A request is any edge on GO relative to the value seen last cycle.
  assign req        = lcd_word_i[10] ^ go_q;
  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == OCC_W'(DEPTH));
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign push       = req && (!fifo_full || pop);
  assign head       = mem_q[rd_ptr_q];
  assign wait_clear = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_SETUP;
          cnt_d   = CNT_W'(T_SETUP - 1);
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = CNT_W'(T_EN - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(T_HOLD - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT;
          cnt_d   = wait_clear ? CNT_W'(T_CLEAR - 1) : CNT_W'(T_EXEC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // GO tracks the input even in reset so releasing reset never looks like a toggle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      go_q     <= lcd_word_i[10];
      on_q     <= 1'b0;
      en_q     <= 1'b0;
      rs_q     <= 1'b0;
      data_q   <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
      go_q    <= lcd_word_i[10];
      on_q    <= lcd_word_i[31];
      en_q    <= (state_d == S_PULSE);
      ovf_q   <= ovf_q | (req & fifo_full & ~pop);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        rs_q     <= head[8];
        data_q   <= head[7:0];
      end
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers and occupancy define validity.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem_q[wr_ptr_q] <= {lcd_word_i[9], lcd_word_i[7:0]};
    end
  end

  assign lcd_on_o     = on_q;
  assign lcd_en_o     = en_q;
  assign lcd_rs_o     = rs_q;
  assign lcd_rw_o     = 1'b0;
  assign lcd_data_o   = data_q;
  assign lcd_status_o = {ovf_q, busy, {(30 - OCC_W){1'b0}}, occ_q};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: directed scenarios with literal expectations plus a long
// randomized run, all compared every cycle against a transaction-level model.
module tb_lcd_ctrl;

  localparam int TS    = 2;
  localparam int TE    = 3;
  localparam int TH    = 2;
  localparam int TX    = 10;
  localparam int TC    = 40;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word;
  logic        lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [7:0]  lcd_data;
  logic [31:0] lcd_status;

  int errors = 0;
  int checks = 0;

  lcd_ctrl #(
    .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_EXEC(TX), .T_CLEAR(TC), .DEPTH(DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .lcd_word_i  (word),
    .lcd_on_o    (lcd_on),
    .lcd_en_o    (lcd_en),
    .lcd_rs_o    (lcd_rs),
    .lcd_rw_o    (lcd_rw),
    .lcd_data_o  (lcd_data),
    .lcd_status_o(lcd_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transaction is a run of L consecutive cycles starting at its first SETUP
  // cycle; m_t is the offset inside that run, EN covers offsets [TS, TS+TE).
  logic [8:0] mq[$];
  bit         m_active, m_go, m_on, m_ovf, m_valid;
  int         m_t, m_len;
  logic       m_rs;
  logic [7:0] m_data;
  bit         m_req, m_pop, m_full;
  logic [8:0] m_e;

  function automatic int wait_of(input logic [8:0] e);
    return (!e[8] && (e[7:0] == 8'h01 || e[7:0] == 8'h02 || e[7:0] == 8'h03)) ? TC : TX;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_active = 0; m_t = 0; m_len = 0;
      m_rs = 0; m_data = 8'h00; m_on = 0; m_ovf = 0;
      m_go = word[10];
    end else begin
      m_req  = (word[10] != m_go);
      m_go   = word[10];
      m_on   = word[31];
      m_full = (mq.size() == DEPTH);
      m_pop  = !m_active && (mq.size() > 0);
      if (m_active) begin
        m_t++;
        if (m_t == m_len) m_active = 0;
      end else if (m_pop) begin
        m_e      = mq.pop_front();
        m_rs     = m_e[8];
        m_data   = m_e[7:0];
        m_active = 1;
        m_t      = 0;
        m_len    = TS + TE + TH + wait_of(m_e);
      end
      if (m_req) begin
        if (!m_full || m_pop) mq.push_back({word[9], word[7:0]});
        else m_ovf = 1;
      end
    end
    m_valid = 1;
  end

  // Outputs are registered, so the falling edge sees the state left by the last rising edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("en",     {31'b0, lcd_en}, {31'b0, (m_active && m_t >= TS && m_t < TS + TE)});
      check("rs",     {31'b0, lcd_rs}, {31'b0, m_rs});
      check("data",   {24'b0, lcd_data}, {24'b0, m_data});
      check("on",     {31'b0, lcd_on}, {31'b0, m_on});
      check("rw",     {31'b0, lcd_rw}, 32'd0);
      check("status", lcd_status,
            ({31'b0, m_ovf} << 31) | ({31'b0, (m_active || mq.size() > 0)} << 30) |
            32'(mq.size()));
    end
  end

  // Records DATA at each rising EN to confirm issue order.
  logic [7:0] issued[$];
  bit         en_prev = 0;
  always @(negedge clk) begin
    if (lcd_en === 1'b1 && !en_prev) issued.push_back(lcd_data);
    en_prev = (lcd_en === 1'b1);
  end

  // ---------------- stimulus helpers ----------------
  bit go_v, on_v;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input bit on, input bit go, input bit rs, input logic [7:0] d,
                       input logic [19:0] jh, input bit jl);
    word = {on, jh, go, rs, jl, d};
  endtask

  task automatic toggle(input bit rs, input logic [7:0] d);
    go_v = !go_v;
    drive(on_v, go_v, rs, d, 20'h0, 1'b0);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (lcd_status[30] !== 1'b0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'b0, lcd_status[30]}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    int en_cnt;
    bit prev_on;
    logic [7:0] exp_d;

    rst = 1'b1; go_v = 1'b1; on_v = 1'b0;
    drive(on_v, go_v, 1'b0, 8'h00, 20'h0, 1'b0);
    repeat (3) tick();
    check("rst_status", lcd_status, 32'd0);
    check("rst_en",     {31'b0, lcd_en}, 32'd0);
    check("rst_on",     {31'b0, lcd_on}, 32'd0);
    check("rst_data",   {24'b0, lcd_data}, 32'd0);
    rst = 1'b0;
    tick();

    // Single data write: setup/pulse/hold/exec timing.
    toggle(1'b1, 8'h41);
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (j == 2)  begin
        check("w1_rs",   {31'b0, lcd_rs}, 32'd1);
        check("w1_data", {24'b0, lcd_data}, 32'h41);
      end
      if (j == 3)  check("w1_en_before", {31'b0, lcd_en}, 32'd0);
      if (j == 4)  check("w1_en_rise",   {31'b0, lcd_en}, 32'd1);
      if (j == 6)  check("w1_en_last",   {31'b0, lcd_en}, 32'd1);
      if (j == 7)  check("w1_en_fall",   {31'b0, lcd_en}, 32'd0);
      if (j == 18) check("w1_busy_end",  {31'b0, lcd_status[30]}, 32'd1);
      if (j == 19) check("w1_busy_fall", {31'b0, lcd_status[30]}, 32'd0);
    end

    // Clear command uses the long wait.
    toggle(1'b0, 8'h01);
    en_cnt = 0;
    for (int j = 1; j <= 50; j++) begin
      tick();
      en_cnt += int'(lcd_en);
      if (j == 48) check("clr_busy_end",  {31'b0, lcd_status[30]}, 32'd1);
      if (j == 49) check("clr_busy_fall", {31'b0, lcd_status[30]}, 32'd0);
    end
    check("clr_en_len", en_cnt, 32'd3);

    // Other bits and ON changes without a GO toggle.
    en_cnt = 0;
    for (int j = 0; j < 12; j++) begin
      on_v = (j % 3 != 0);
      drive(on_v, go_v, 1'($urandom), 8'($urandom), 20'($urandom), 1'($urandom));
      tick();
      en_cnt += int'(lcd_en);
      check("on_follow", {31'b0, lcd_on}, {31'b0, on_v});
    end
    check("no_go_en", en_cnt, 32'd0);
    check("no_go_busy", {31'b0, lcd_status[30]}, 32'd0);

    // Six back-to-back requests into a depth-4 queue: last one drops.
    issued.delete();
    for (int i = 0; i < 6; i++) begin
      toggle(1'b1, 8'(8'h30 + i));
      tick();
    end
    wait_idle(300);
    check("ovf_count", issued.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      exp_d = 8'(8'h30 + i);
      check("ovf_order", (i < issued.size()) ? {24'b0, issued[i]} : 32'hFFFF_FFFF, {24'b0, exp_d});
    end
    check("ovf_set", {31'b0, lcd_status[31]}, 32'd1);
    toggle(1'b1, 8'h77);
    tick();
    wait_idle(100);
    check("ovf_sticky", {31'b0, lcd_status[31]}, 32'd1);
    do_reset();
    check("ovf_cleared", {31'b0, lcd_status[31]}, 32'd0);

    // Full queue plus simultaneous pop and push.
    toggle(1'b1, 8'h50);
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (j <= 4) toggle(1'b1, 8'(8'h50 + j));
      if (j == 19) begin
        check("full_occ_before", {29'b0, lcd_status[2:0]}, 32'd4);
        check("full_idle_en",    {31'b0, lcd_en}, 32'd0);
        toggle(1'b1, 8'h55);
      end
      if (j == 20) begin
        check("full_occ_after", {29'b0, lcd_status[2:0]}, 32'd4);
        check("full_no_ovf",    {31'b0, lcd_status[31]}, 32'd0);
      end
    end
    wait_idle(500);
    check("full_ovf_final", {31'b0, lcd_status[31]}, 32'd0);

    // Reset in the middle of the EN pulse.
    toggle(1'b1, 8'h60);
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (j == 1) toggle(1'b1, 8'h61);
      if (j == 2) toggle(1'b1, 8'h62);
      if (j == 5) begin
        check("mid_en_high", {31'b0, lcd_en}, 32'd1);
        check("mid_occ",     {29'b0, lcd_status[2:0]}, 32'd2);
        rst = 1'b1;
      end
      if (j == 6) begin
        check("mid_en_drop", {31'b0, lcd_en}, 32'd0);
        check("mid_status",  lcd_status, 32'd0);
        rst = 1'b0;
      end
    end
    en_cnt = 0;
    for (int j = 0; j < 30; j++) begin
      tick();
      en_cnt += int'(lcd_en);
    end
    check("mid_no_pulse", en_cnt, 32'd0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      rst  = ($urandom_range(0, 599) == 0);
      on_v = 1'($urandom);
      if ($urandom_range(0, 15) < 2) go_v = !go_v;
      if ($urandom_range(0, 3) == 0) exp_d = 8'($urandom_range(0, 4));
      else exp_d = 8'($urandom);
      drive(on_v, go_v, ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1, exp_d,
            20'($urandom), 1'($urandom));
      tick();
    end
    rst = 1'b0;
    wait_idle(2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
